// File: rtl/err_recovery_seq.sv
// Error-recovery sequencer: adds the most-significant error slices onto an approximate sum, one slice per cycle.
// Optional error-operation counter on port err_cnt is enabled by defining ERR_RECOVERY_STAT_EN.
module err_recovery_seq #(
  parameter int SLICE_W    = 4,
  parameter int REC_SLICES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] e1_in,
  input  logic [15:0] ep_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] p_out
`ifdef ERR_RECOVERY_STAT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CORRECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  // Slices are applied from k=3 downwards; this is the last one that gets added.
  localparam int         LAST_K   = (REC_SLICES > 0) ? 4 - REC_SLICES : 0;
  localparam logic [1:0] LAST_IDX = LAST_K[1:0];

  logic [1:0]         state;
  logic [32:0]        acc;
  logic [15:0]        slice_reg;
  logic [1:0]         slice_idx;
  logic               ready_en;
  logic [SLICE_W-1:0] nib;
  logic [5:0]         shamt;
  logic [32:0]        slice_term;

  always_comb begin
    nib        = slice_reg[slice_idx*SLICE_W +: SLICE_W];
    shamt      = 6'(10 + SLICE_W * int'(slice_idx));
    slice_term = 33'(nib) << shamt;
  end

  assign in_ready  = ready_en && (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign p_out     = acc;

  // ready_en holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      slice_reg <= '0;
      slice_idx <= '0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            acc       <= {e1_in, 1'b0};
            slice_reg <= ep_in;
            slice_idx <= 2'd3;
            state     <= (REC_SLICES > 0) ? S_CORRECT : S_DONE;
          end
        end
        S_CORRECT: begin
          acc <= acc + slice_term;
          if (slice_idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            slice_idx <= slice_idx - 2'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ERR_RECOVERY_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (in_valid && in_ready && (ep_in != '0) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_err_recovery_seq.sv
// Bench for err_recovery_seq: three instances (4, 2 and 0 recovered slices) against a transaction-level model.
// Defining ERR_RECOVERY_STAT_EN also exercises the err_cnt port.
module tb_err_recovery_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [3];
  logic [30:0] e1   [3];
  logic [15:0] ep   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [32:0] po   [3];
`ifdef ERR_RECOVERY_STAT_EN
  logic [7:0]  ec   [3];
`endif

  int checks = 0;
  int errors = 0;

  // Model state per instance: phase 0 idle, 1 busy, 2 result held.
  int     m_phase [3] = '{default: 0};
  int     m_cnt   [3] = '{default: 0};
  longint m_res   [3] = '{default: 0};
  bit     m_armed [3] = '{default: 0};
  int     m_err   [3] = '{default: 0};

  always #5 clk = ~clk;

  err_recovery_seq #(.REC_SLICES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .e1_in(e1[0]), .ep_in(ep[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .p_out(po[0])
`ifdef ERR_RECOVERY_STAT_EN
    , .err_cnt(ec[0])
`endif
  );

  err_recovery_seq #(.REC_SLICES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .e1_in(e1[1]), .ep_in(ep[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .p_out(po[1])
`ifdef ERR_RECOVERY_STAT_EN
    , .err_cnt(ec[1])
`endif
  );

  err_recovery_seq #(.REC_SLICES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .e1_in(e1[2]), .ep_in(ep[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .p_out(po[2])
`ifdef ERR_RECOVERY_STAT_EN
    , .err_cnt(ec[2])
`endif
  );

  function automatic int rec_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 0);
  endfunction

  // Recovered value: doubled sum plus the top 4*R bits of the error vector weighted by 2^10.
  function automatic longint expect_result(input int r, input logic [30:0] a, input logic [15:0] b);
    int m;
    m = (r == 0) ? 0 : ((32'hFFFF << (16 - 4 * r)) & 32'hFFFF);
    return 2 * longint'(a) + 1024 * longint'(int'(b) & m);
  endfunction

  task automatic check_output(input string name, input int i, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Every falling edge: compare against the model, then advance it with the inputs the next rising edge sees.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_phase[i] = 0;
        m_armed[i] = 0;
        m_err[i]   = 0;
      end
      check_output("in_ready", i, ir[i], longint'(m_armed[i] && m_phase[i] == 0));
      check_output("out_valid", i, ov[i], longint'(m_phase[i] == 2));
      if (!rst_n) check_output("p_out_reset", i, po[i], 0);
      else if (m_phase[i] == 2) check_output("p_out", i, po[i], m_res[i]);
`ifdef ERR_RECOVERY_STAT_EN
      check_output("err_cnt", i, ec[i], m_err[i]);
`endif
      if (rst_n) begin
        case (m_phase[i])
          0: if (m_armed[i] && iv[i]) begin
               m_res[i] = expect_result(rec_of(i), e1[i], ep[i]);
               if (ep[i] != 0 && m_err[i] < 255) m_err[i]++;
               m_cnt[i]   = rec_of(i);
               m_phase[i] = (rec_of(i) == 0) ? 2 : 1;
             end
          1: begin
               m_cnt[i]--;
               if (m_cnt[i] == 0) m_phase[i] = 2;
             end
          default: if (ordy[i]) m_phase[i] = 0;
        endcase
        m_armed[i] = 1;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Wait for in_ready, transfer one pair, then count cycles until out_valid.
  task automatic apply_stimulus(input int i, input logic [30:0] a, input logic [15:0] b, output int lat);
    int n;
    n = 0;
    while (!ir[i] && n < 20) begin
      next_cycle();
      n++;
    end
    check_output("in_ready_wait", i, ir[i], 1);
    iv[i] = 1'b1;
    e1[i] = a;
    ep[i] = b;
    next_cycle();
    iv[i] = 1'b0;
    e1[i] = 31'($urandom);
    ep[i] = 16'($urandom);
    lat = 0;
    while (!ov[i] && lat < 20) begin
      next_cycle();
      lat++;
    end
    check_output("out_valid_wait", i, ov[i], 1);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; e1[i] = '0; ep[i] = '0;
    end
    next_cycle();
    repeat (5) begin
      for (int i = 0; i < 3; i++) begin
        iv[i] = 1'($urandom); e1[i] = 31'($urandom); ep[i] = 16'($urandom);
      end
      next_cycle();
    end
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    rst_n = 1'b1;
    next_cycle();
    check_output("in_ready_after_reset", 0, ir[0], 1);

    apply_stimulus(0, 31'h1, 16'h0001, lat);
    check_output("lat_r4", 0, lat, 4);
    check_output("p_out_r4_small", 0, po[0], 33'h402);
    next_cycle();
    apply_stimulus(1, 31'h0, 16'hFFFF, lat);
    check_output("lat_r2", 1, lat, 2);
    check_output("p_out_r2_ffff", 1, po[1], 33'h3FC0000);
    next_cycle();
    apply_stimulus(0, 31'h0, 16'hFFFF, lat);
    check_output("p_out_r4_ffff", 0, po[0], 33'h3FFFC00);
    next_cycle();
    apply_stimulus(2, 31'h5, 16'hFFFF, lat);
    check_output("p_out_r0", 2, po[2], 33'hA);
    next_cycle();

    // Backpressure: result must hold and a stray in_valid must be ignored.
    ordy[0] = 1'b0;
    apply_stimulus(0, 31'h123, 16'hABCD, lat);
    check_output("p_out_bp", 0, po[0], 33'h2AF3646);
    for (int k = 0; k < 5; k++) begin
      iv[0] = (k == 2);
      e1[0] = 31'($urandom);
      ep[0] = 16'($urandom);
      next_cycle();
      check_output("p_out_hold", 0, po[0], 33'h2AF3646);
      check_output("in_ready_hold", 0, ir[0], 0);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    next_cycle();
    check_output("in_ready_after_out", 0, ir[0], 1);

    // Reset two cycles into CORRECT discards the operation.
    iv[0] = 1'b1; e1[0] = 31'h7FFF_FFFF; ep[0] = 16'h1234;
    next_cycle();
    iv[0] = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    check_output("mid_reset_out_valid", 0, ov[0], 0);
    check_output("mid_reset_p_out", 0, po[0], 0);
    check_output("mid_reset_in_ready", 0, ir[0], 0);
    next_cycle();
    rst_n = 1'b1;
    repeat (8) begin
      next_cycle();
      check_output("no_pulse_after_reset", 0, ov[0], 0);
    end

`ifdef ERR_RECOVERY_STAT_EN
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    for (int n = 0; n < 310; n++) begin
      apply_stimulus(0, 31'($urandom), (n < 300) ? 16'($urandom_range(1, 65535)) : 16'h0, lat);
      next_cycle();
    end
    check_output("err_cnt_saturate", 0, ec[0], 255);
`endif

    repeat (600) begin
      for (int i = 0; i < 3; i++) begin
        iv[i]   = 1'($urandom_range(0, 1));
        e1[i]   = 31'($urandom);
        ep[i]   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (8) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
